audio_tone_gen: RTL

Parametrised multi-channel tone generator feeding the `audio_data` input of `hdmi`. It is the successor to the single fixed-rate sawtooth source and replaces it in the top level. Each channel has its own phase accumulator, waveform, frequency step and attenuation. Configuration updates arrive over a valid/ready port and are applied at the channel's phase wrap, so a retune never tears a cycle.

---
 rtl/audio_pkg.sv | 33 +++
 rtl/audio_tone_gen_shaper.sv | 38 +++
 rtl/audio_tone_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types for the multi-channel tone generator.
//   wave_e        waveform selector carried on cfg_wave
//   slot_state_e  state of the single configuration slot
//   cfg_t         captured configuration request {chan, step, wave, shift}
// cfg_t fields are sized for the largest supported configuration
// (up to 256 channels, 32-bit phase, 8-bit shift). Narrower instances
// zero-extend into it and read back only the bits they use.
package audio_pkg;

  typedef enum logic [1:0] {
    SAW    = 2'd0,
    SQUARE = 2'd1,
    TRI    = 2'd2,
    SILENT = 2'd3
  } wave_e;

  typedef enum logic {
    SLOT_IDLE    = 1'b0,
    SLOT_PENDING = 1'b1
  } slot_state_e;

  localparam int CFG_CHAN_W  = 8;
  localparam int CFG_STEP_W  = 32;
  localparam int CFG_SHIFT_W = 8;

  typedef struct packed {
    logic [CFG_CHAN_W-1:0]  chan;
    logic [CFG_STEP_W-1:0]  step;
    wave_e                  wave;
    logic [CFG_SHIFT_W-1:0] shift;
  } cfg_t;

endpackage

// File: rtl/audio_tone_gen_shaper.sv
// tone_shaper: purely combinational waveform shaping for one channel.
//   phase   in  W            top bits of the phase accumulator
//   wave    in  wave_e       waveform select
//   shift   in  SHIFT_WIDTH  arithmetic right-shift attenuation
//   sample  out W            signed (two's complement) sample
// Unsigned ramps are turned into signed samples by inverting the MSB,
// which is the same as subtracting half scale.
module tone_shaper
  import audio_pkg::*;
#(
  parameter int W           = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic [W-1:0]           phase,
  input  wave_e                  wave,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [W-1:0]           sample
);

  logic [W-1:0] dbl;
  logic [W-1:0] tri_u;
  logic [W-1:0] shaped;

  always_comb begin
    dbl    = phase << 1;
    // Fold the second half of the period back down to get a symmetric ramp.
    tri_u  = phase[W-1] ? ~dbl : dbl;
    shaped = '0;
    case (wave)
      SAW:     shaped = {~phase[W-1], phase[W-2:0]};
      SQUARE:  shaped = phase[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      TRI:     shaped = {~tri_u[W-1], tri_u[W-2:0]};
      default: shaped = '0;
    endcase
    sample = $unsigned($signed(shaped) >>> shift);
  end

endmodule

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: multi-channel tone generator for the hdmi audio input.
//   clk_audio    in   sole clock
//   rst          in   synchronous active-high reset
//   sample_en    in   one-cycle sample strobe
//   cfg_valid    in   configuration request
//   cfg_ready    out  configuration slot free (registered)
//   cfg_chan     in   target channel
//   cfg_step     in   phase increment per sample
//   cfg_wave     in   0 saw, 1 square, 2 triangle, 3 silence
//   cfg_shift    in   attenuation (arithmetic right shift)
//   audio_data   out  one registered signed sample per channel
//   audio_valid  out  one-cycle pulse per produced sample set
//   dbg_slot_state out  current configuration slot state
//
// Handshake: a request transfers on any cycle where cfg_valid && cfg_ready.
// cfg_ready is a register, so it never depends combinationally on cfg_*.
// After a transfer the slot holds the request until it is applied at the
// target channel's phase wrap (or at once if the channel is silent or has a
// zero step), then frees itself; requests for a nonexistent channel are
// dropped one cycle after transfer.
module audio_tone_gen
  import audio_pkg::*;
#(
  parameter int  AUDIO_BIT_WIDTH = 16,
  parameter int  CHANNELS        = 2,
  parameter int  PHASE_WIDTH     = 24,
  parameter int  SHIFT_WIDTH     = 4,
  localparam int CW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                       clk_audio,
  input  logic                                       rst,
  input  logic                                       sample_en,
  input  logic                                       cfg_valid,
  output logic                                       cfg_ready,
  input  logic [CW-1:0]                              cfg_chan,
  input  logic [PHASE_WIDTH-1:0]                     cfg_step,
  input  logic [1:0]                                 cfg_wave,
  input  logic [SHIFT_WIDTH-1:0]                     cfg_shift,
  output logic [CHANNELS-1:0][AUDIO_BIT_WIDTH-1:0]   audio_data,
  output logic                                       audio_valid,
  output slot_state_e                                dbg_slot_state
);

  // Per-channel state
  logic [PHASE_WIDTH-1:0]     acc_q   [CHANNELS];
  logic [PHASE_WIDTH-1:0]     step_q  [CHANNELS];
  wave_e                      wave_q  [CHANNELS];
  logic [SHIFT_WIDTH-1:0]     shift_q [CHANNELS];
  logic [PHASE_WIDTH-1:0]     acc_sum [CHANNELS];
  logic [AUDIO_BIT_WIDTH-1:0] shaped  [CHANNELS];
  logic [CHANNELS-1:0]        wrap;
  logic [CHANNELS-1:0]        sel;

  // Configuration slot
  slot_state_e state_q, state_d;
  cfg_t        pend_q, pend_d;
  logic        ready_q;
  logic        chan_ok;
  logic        tgt_quiet;
  logic        tgt_wrap;
  logic        apply;
  logic        apply_clear;
  logic        unused_pend;

  assign cfg_ready      = ready_q;
  assign dbg_slot_state = state_q;
  // Only the low bits of the wide capture fields are consumed here.
  assign unused_pend    = ^pend_q;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      {wrap[c], acc_sum[c]} = {1'b0, acc_q[c]} + {1'b0, step_q[c]};
    end
  end

  always_comb begin
    chan_ok = int'(pend_q.chan) < CHANNELS;
    for (int c = 0; c < CHANNELS; c++) begin
      sel[c] = chan_ok && (int'(pend_q.chan) == c);
    end
  end

  // Slot next-state logic
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    apply       = 1'b0;
    apply_clear = 1'b0;
    tgt_quiet   = 1'b0;
    tgt_wrap    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel[c]) begin
        tgt_quiet = tgt_quiet | (wave_q[c] == SILENT) | (step_q[c] == '0);
        tgt_wrap  = tgt_wrap | (sample_en & wrap[c]);
      end
    end
    case (state_q)
      SLOT_IDLE: begin
        if (cfg_valid && ready_q) begin
          pend_d.chan  = CFG_CHAN_W'(cfg_chan);
          pend_d.step  = CFG_STEP_W'(cfg_step);
          pend_d.wave  = wave_e'(cfg_wave);
          pend_d.shift = CFG_SHIFT_W'(cfg_shift);
          state_d      = SLOT_PENDING;
        end
      end
      SLOT_PENDING: begin
        if (!chan_ok) begin
          state_d = SLOT_IDLE;
        end else if (tgt_quiet) begin
          // Nothing audible to tear, so restart the phase from zero now.
          apply       = 1'b1;
          apply_clear = 1'b1;
          state_d     = SLOT_IDLE;
        end else if (tgt_wrap) begin
          apply   = 1'b1;
          state_d = SLOT_IDLE;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge clk_audio) begin
    if (rst) begin
      state_q <= SLOT_IDLE;
      pend_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ready_q <= (state_d == SLOT_IDLE);
    end
  end

  // Channel datapath. The accumulate in an apply cycle still uses the old
  // step; an immediate apply overrides it with a cleared accumulator.
  always_ff @(posedge clk_audio) begin
    if (rst) begin
      audio_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]      <= '0;
        step_q[c]     <= '0;
        wave_q[c]     <= SILENT;
        shift_q[c]    <= '0;
        audio_data[c] <= '0;
      end
    end else begin
      audio_valid <= sample_en;
      for (int c = 0; c < CHANNELS; c++) begin
        if (sample_en) begin
          acc_q[c]      <= acc_sum[c];
          audio_data[c] <= shaped[c];
        end
        if (apply && sel[c]) begin
          step_q[c]  <= pend_q.step[PHASE_WIDTH-1:0];
          wave_q[c]  <= pend_q.wave;
          shift_q[c] <= pend_q.shift[SHIFT_WIDTH-1:0];
          if (apply_clear) begin
            acc_q[c] <= '0;
          end
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    tone_shaper #(
      .W           (AUDIO_BIT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shaper (
      .phase  (acc_q[c][PHASE_WIDTH-1 -: AUDIO_BIT_WIDTH]),
      .wave   (wave_q[c]),
      .shift  (shift_q[c]),
      .sample (shaped[c])
    );
  end

endmodule
